gf180mcu_fd_sc_mcu9t5v0__aoi21_bist: RTL and testbench

//  Self-test sequencer that sits around one aoi21 cell instance: it drives A1/A2/B and consumes ZN.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.sv | 164 ++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.sv
// gf180mcu_fd_sc_mcu9t5v0__aoi21_bist
// Self-test sequencer wrapped around one aoi21 cell. It drives A1/A2/B with
// every 3-bit vector in ascending order and lets each vector settle. It then
// checks ZN against ~((A1&A2)|B). The results are a pass flag, a saturating
// mismatch count and the first failing vector.
//
// Optional feature: define GF180MCU_AOI21_BIST_STOP_ON_FAIL_EN to end the
// sweep at the first mismatch instead of running every vector.
module gf180mcu_fd_sc_mcu9t5v0__aoi21_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4,
    parameter int PASSES        = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             A1,
    output logic             A2,
    output logic             B,
    input  logic             ZN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [2:0]       FAIL_VEC,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = $clog2(PASSES + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [2:0]       vec;
    logic [SW-1:0]    settle_cnt;
    logic [PW-1:0]    pass_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic [2:0]       fail_vec;

    logic golden;
    logic mismatch;
    logic start_accept;
    logic settle_last;
    logic sweep_last;
    logic stop_now;
    logic finish_now;

    // The supply pins carry no logic. They are folded into a dummy net only
    // so that they do not show up as dangling.
    wire unused_supply = VDD ^ VSS;

    assign golden       = ~((vec[2] & vec[1]) | vec[0]);
    // With case inequality, an X or Z on ZN also counts as a failure.
    assign mismatch     = (ZN !== golden);
    assign start_accept = START && ((state == ST_IDLE) || (state == ST_DONE));
    assign settle_last  = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign sweep_last   = (vec == 3'd7) && (pass_cnt == PW'(PASSES - 1));

`ifdef GF180MCU_AOI21_BIST_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    assign finish_now = stop_now || sweep_last;

    // State register for the sequencer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. START is only honoured when no sweep is running.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (START) next_state = ST_SETTLE;
            ST_SETTLE:  if (settle_last) next_state = ST_COMPARE;
            ST_COMPARE: next_state = finish_now ? ST_DONE : ST_SETTLE;
            ST_DONE:    if (START) next_state = ST_SETTLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the state and the stored results.
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        PASS = 1'b0;
        case (state)
            ST_SETTLE, ST_COMPARE: BUSY = 1'b1;
            ST_DONE: begin
                DONE = 1'b1;
                PASS = (err_cnt == '0);
            end
            default: ;
        endcase
    end

    // Vector, counters and results. A new START clears all of them. A vector
    // advances only when leaving COMPARE, so the drives change on SETTLE entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vec        <= 3'd0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            err_cnt    <= '0;
            fail_vec   <= 3'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_accept) begin
                        vec        <= 3'd0;
                        settle_cnt <= '0;
                        pass_cnt   <= '0;
                        err_cnt    <= '0;
                        fail_vec   <= 3'd0;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_last ? '0 : settle_cnt + 1'b1;
                end
                ST_COMPARE: begin
                    if (mismatch) begin
                        if (err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        // The count never returns to zero once it saturates,
                        // so a zero count means this is the first failure.
                        if (err_cnt == '0) begin
                            fail_vec <= vec;
                        end
                    end
                    if (!finish_now) begin
                        vec <= vec + 3'd1;
                        if (vec == 3'd7) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign A1       = vec[2];
    assign A2       = vec[1];
    assign B        = vec[0];
    assign ERR_CNT  = err_cnt;
    assign FAIL_VEC = fail_vec;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.sv
// Testbench for gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.
// It builds two instances: one with the default parameters, and one with
// ERR_W=2, PASSES=2 to exercise counter saturation.
// Each stimulus pushes its expected result record. A monitor per instance
// pops that record and compares it when DONE rises.
// The expected values follow GF180MCU_AOI21_BIST_STOP_ON_FAIL_EN when it is
// defined.
module tb_gf180mcu_fd_sc_mcu9t5v0__aoi21_bist;

`ifdef GF180MCU_AOI21_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    localparam int MODE_GOOD  = 0;
    localparam int MODE_TIED0 = 1;
    localparam int MODE_TIED1 = 2;

    typedef struct {
        string      name;
        int         lat;
        int         err;
        bit         pass;
        logic [2:0] fv;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;

    logic       start0 = 1'b0;
    logic       a1_0, a2_0, b_0, zn0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [2:0] fv0;
    int         mode0 = MODE_GOOD;

    logic       start1 = 1'b0;
    logic       a1_1, a2_1, b_1, zn1, busy1, done1, pass1;
    logic [1:0] err1;
    logic [2:0] fv1;
    int         mode1 = MODE_GOOD;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   lat0 = 0, lat1 = 0;
    logic busy0_q = 1'b0, done0_q = 1'b0, busy1_q = 1'b0, done1_q = 1'b0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu9t5v0__aoi21_bist dut0 (
        .CLK(CLK), .RST(RST), .START(start0),
        .A1(a1_0), .A2(a2_0), .B(b_0), .ZN(zn0),
        .BUSY(busy0), .DONE(done0), .PASS(pass0),
        .ERR_CNT(err0), .FAIL_VEC(fv0),
        .VDD(vdd), .VSS(vss)
    );

    gf180mcu_fd_sc_mcu9t5v0__aoi21_bist #(
        .SETTLE_CYCLES(2), .ERR_W(2), .PASSES(2)
    ) dut1 (
        .CLK(CLK), .RST(RST), .START(start1),
        .A1(a1_1), .A2(a2_1), .B(b_1), .ZN(zn1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .ERR_CNT(err1), .FAIL_VEC(fv1),
        .VDD(vdd), .VSS(vss)
    );

    // Cell under test: either a healthy aoi21 or a stuck-at output.
    function automatic logic zn_model(input int mode, input logic a1, input logic a2, input logic b);
        case (mode)
            MODE_TIED0: return 1'b0;
            MODE_TIED1: return 1'b1;
            default:    return ~((a1 & a2) | b);
        endcase
    endfunction

    assign zn0 = zn_model(mode0, a1_0, a2_0, b_0);
    assign zn1 = zn_model(mode1, a1_1, a2_1, b_1);

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor for dut0. It measures cycles from the START-accept edge and
    // scores each completed run against the head of its queue.
    always @(negedge CLK) begin
        if (busy0 === 1'b1 && busy0_q !== 1'b1) lat0 = 0;
        else lat0 = lat0 + 1;
        if (done0 === 1'b1 && done0_q !== 1'b1) begin
            if (q0.size() == 0) begin
                checkOutput("dut0 unexpected DONE", 1, 0);
            end else begin
                e0 = q0.pop_front();
                checkOutput({e0.name, " latency"}, lat0, e0.lat);
                checkOutput({e0.name, " ERR_CNT"}, int'(err0), e0.err);
                checkOutput({e0.name, " PASS"}, int'(pass0), int'(e0.pass));
                checkOutput({e0.name, " FAIL_VEC"}, int'(fv0), int'(e0.fv));
                checkOutput({e0.name, " BUSY low"}, int'(busy0), 0);
            end
        end
        busy0_q = busy0;
        done0_q = done0;
    end

    // Monitor for dut1. It does the same scoring as the dut0 monitor.
    always @(negedge CLK) begin
        if (busy1 === 1'b1 && busy1_q !== 1'b1) lat1 = 0;
        else lat1 = lat1 + 1;
        if (done1 === 1'b1 && done1_q !== 1'b1) begin
            if (q1.size() == 0) begin
                checkOutput("dut1 unexpected DONE", 1, 0);
            end else begin
                e1 = q1.pop_front();
                checkOutput({e1.name, " latency"}, lat1, e1.lat);
                checkOutput({e1.name, " ERR_CNT"}, int'(err1), e1.err);
                checkOutput({e1.name, " PASS"}, int'(pass1), int'(e1.pass));
                checkOutput({e1.name, " FAIL_VEC"}, int'(fv1), int'(e1.fv));
            end
        end
        busy1_q = busy1;
        done1_q = done1;
    end

    // Start one run on the chosen instance and queue its expected result.
    // The task checks that the run began with cleared results, then waits
    // (bounded) for the monitor to consume the record. If repulse > 0,
    // START is pulsed again that many cycles into the run.
    task automatic applyStimulus(input int dut, input int mode, input string name,
                                 input int lat, input int err, input bit pass,
                                 input logic [2:0] fv, input int repulse);
        exp_t e;
        e.name = name; e.lat = lat; e.err = err; e.pass = pass; e.fv = fv;
        @(negedge CLK);
        if (dut == 0) begin mode0 = mode; q0.push_back(e); start0 = 1'b1; end
        else          begin mode1 = mode; q1.push_back(e); start1 = 1'b1; end
        @(negedge CLK);
        start0 = 1'b0;
        start1 = 1'b0;
        if (dut == 0) begin
            checkOutput({name, " started BUSY"}, int'(busy0), 1);
            checkOutput({name, " started ERR_CNT clear"}, int'(err0), 0);
        end else begin
            checkOutput({name, " started BUSY"}, int'(busy1), 1);
            checkOutput({name, " started ERR_CNT clear"}, int'(err1), 0);
        end
        if (repulse > 0) begin
            repeat (repulse - 1) @(negedge CLK);
            if (dut == 0) start0 = 1'b1; else start1 = 1'b1;
            @(negedge CLK);
            start0 = 1'b0;
            start1 = 1'b0;
        end
        for (int i = 0; i < 200 && ((dut == 0) ? q0.size() : q1.size()) != 0; i++)
            @(negedge CLK);
        if (((dut == 0) ? q0.size() : q1.size()) != 0) begin
            checkOutput({name, " DONE timeout"}, 0, 1);
            if (dut == 0) q0.delete(); else q1.delete();
        end
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, " BUSY"}, int'(busy0), 0);
        checkOutput({name, " DONE"}, int'(done0), 0);
        checkOutput({name, " PASS"}, int'(pass0), 0);
        checkOutput({name, " ERR_CNT"}, int'(err0), 0);
        checkOutput({name, " FAIL_VEC"}, int'(fv0), 0);
        checkOutput({name, " drives"}, int'({a1_0, a2_0, b_0}), 0);
        checkOutput({name, " dut1 DONE"}, int'(done1), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checkReset("reset");
        RST = 1'b0;

        // Healthy cell, a cell stuck at 0, and a cell stuck at 1.
        applyStimulus(0, MODE_GOOD,  "good",  24, 0, 1'b1, 3'b000, 0);
        applyStimulus(0, MODE_TIED0, "tied0", STOP ? 3 : 24, STOP ? 1 : 3, 1'b0, 3'b000, 0);

        // DONE and the results hold until the next START.
        repeat (4) @(negedge CLK);
        checkOutput("tied0 DONE held", int'(done0), 1);
        checkOutput("tied0 ERR_CNT held", int'(err0), STOP ? 1 : 3);

        // A START while in DONE restarts the sweep with cleared results.
        applyStimulus(0, MODE_TIED1, "tied1", STOP ? 6 : 24, STOP ? 1 : 5, 1'b0, 3'b001, 0);

        // A START pulse in the middle of a sweep is ignored.
        applyStimulus(0, MODE_GOOD, "busy restart", 24, 0, 1'b1, 3'b000, 5);

        // Reset at cycle 10 of a sweep aborts it. The next run is clean.
        @(negedge CLK);
        mode0 = MODE_TIED1;
        start0 = 1'b1;
        @(negedge CLK);
        start0 = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkReset("mid-sweep reset");
        RST = 1'b0;
        applyStimulus(0, MODE_TIED1, "after reset", STOP ? 6 : 24, STOP ? 1 : 5, 1'b0, 3'b001, 0);

        // Two-pass instance with a 2-bit counter: ten stuck-at-1 mismatches
        // saturate the count at 3.
        applyStimulus(1, MODE_TIED1, "sat tied1", STOP ? 6 : 48, STOP ? 1 : 3, 1'b0, 3'b001, 0);
        applyStimulus(1, MODE_GOOD,  "two-pass good", 48, 0, 1'b1, 3'b000, 0);

        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
